// File: rtl/vc_pkg.sv
// Shared definitions for the valid/ready <-> valid/credit converter pair.
// Both sides derive the credit counter width from the same function.
package vc_pkg;

    localparam int DEFAULT_CREDIT_NUM = 2;

    function automatic int credit_w(input int n);
        return $clog2(n + 1);
    endfunction

    typedef logic [credit_w(DEFAULT_CREDIT_NUM)-1:0] credit_cnt_t;

endpackage

// File: rtl/vc_credit_counter.sv
// Saturating credit counter: +1 on inc, -1 on dec, sticky ovf on inc at MAX.
// Latency: count updates one edge after inc/dec; no backpressure (caller must not dec at zero).
// Backpressure: none; nonzero is the consumer's permission to dec.
module vc_credit_counter
    import vc_pkg::*;
#(
    parameter int MAX = 2,
    localparam int W = credit_w(MAX)
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         inc,
    input  logic         dec,
    output logic [W-1:0] cnt,
    output logic         nonzero,
    output logic         ovf
);

    localparam logic [W-1:0] MAX_CNT = W'(MAX);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt <= '0;
            ovf <= 1'b0;
        end else begin
            case ({inc, dec})
                2'b10: begin
                    // A return with a full counter means the receiver over-granted.
                    if (cnt == MAX_CNT) ovf <= 1'b1;
                    else                cnt <= cnt + W'(1);
                end
                2'b01:   cnt <= cnt - W'(1);
                default: cnt <= cnt;
            endcase
        end
    end

    assign nonzero = (cnt != '0);

endmodule

// File: rtl/vr_vc_converter.sv
// Valid/ready to valid/credit bridge: each accepted beat becomes a one-cycle m_valid_o pulse.
// Latency: 1 cycle from s-side fire to m_valid_o; 1 beat/cycle while credits last.
// Backpressure: s_ready_o drops as soon as the credit count reaches zero; no internal buffering.
module vr_vc_converter
    import vc_pkg::*;
#(
    parameter int DATA_WIDTH = 8,
    parameter int CREDIT_NUM = 2,
    localparam int CNT_W = credit_w(CREDIT_NUM)
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic [DATA_WIDTH-1:0] s_data_i,
    input  logic                  s_valid_i,
    output logic                  s_ready_o,
    output logic [DATA_WIDTH-1:0] m_data_o,
    output logic                  m_valid_o,
    input  logic                  m_credit_i,
    output logic [CNT_W-1:0]      credit_cnt_o,
    output logic                  credit_ovf_o
);

    logic fire;
    logic have_credit;

    assign s_ready_o = have_credit;
    assign fire      = s_valid_i & have_credit;

    vc_credit_counter #(
        .MAX(CREDIT_NUM)
    ) u_credit (
        .clk    (clk),
        .rst    (rst),
        .inc    (m_credit_i),
        .dec    (fire),
        .cnt    (credit_cnt_o),
        .nonzero(have_credit),
        .ovf    (credit_ovf_o)
    );

    // Payload only moves on fire so the link data is stable between beats.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            m_valid_o <= 1'b0;
            m_data_o  <= '0;
        end else begin
            m_valid_o <= fire;
            if (fire) m_data_o <= s_data_i;
        end
    end

endmodule

// File: tb/tb_vr_vc_converter.sv
// Self-checking bench for vr_vc_converter: directed scenarios plus a randomized
// end-to-end run against a credit-returning receiver model.
module tb_vr_vc_converter;
    localparam int DW = 8;
    localparam int CN = 2;
    localparam int CW = $clog2(CN + 1);

    logic          clk = 1'b0;
    logic          rst;
    logic [DW-1:0] s_data_i;
    logic          s_valid_i;
    logic          s_ready_o;
    logic [DW-1:0] m_data_o;
    logic          m_valid_o;
    logic          m_credit_i;
    logic [CW-1:0] credit_cnt_o;
    logic          credit_ovf_o;

    vr_vc_converter #(.DATA_WIDTH(DW), .CREDIT_NUM(CN)) dut (
        .clk         (clk),
        .rst         (rst),
        .s_data_i    (s_data_i),
        .s_valid_i   (s_valid_i),
        .s_ready_o   (s_ready_o),
        .m_data_o    (m_data_o),
        .m_valid_o   (m_valid_o),
        .m_credit_i  (m_credit_i),
        .credit_cnt_o(credit_cnt_o),
        .credit_ovf_o(credit_ovf_o)
    );

    always #5 clk = ~clk;

    int n_chk  = 0;
    int n_pass = 0;

    // Reference state: credits held, sticky overflow, last emitted beat.
    int            ref_cnt;
    bit            ref_ovf;
    bit            ref_vld;
    logic [DW-1:0] ref_dat;
    logic [DW-1:0] sent_q[$];
    logic [DW-1:0] rx_q[$];

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got === exp) n_pass++;
        else $display("FAIL %s got=%0h exp=%0h at %0t", tag, got, exp, $time);
    endtask

    task automatic ref_reset();
        ref_cnt = 0;
        ref_ovf = 0;
        ref_vld = 0;
        ref_dat = '0;
        sent_q.delete();
        rx_q.delete();
    endtask

    // One clock: drive inputs just after an edge, predict, then check after the next edge.
    task automatic cycle(input bit v, input logic [DW-1:0] d, input bit c, output bit fired);
        s_valid_i  = v;
        s_data_i   = d;
        m_credit_i = c;
        #1;
        chk("ready", s_ready_o, (ref_cnt != 0));
        fired = v && (ref_cnt != 0);
        if (c && !fired && ref_cnt == CN) ref_ovf = 1;
        else ref_cnt = ref_cnt + int'(c) - int'(fired);
        ref_vld = fired;
        if (fired) begin
            ref_dat = d;
            sent_q.push_back(d);
        end
        @(posedge clk);
        #1;
        chk("cnt",   credit_cnt_o, ref_cnt);
        chk("valid", m_valid_o,    ref_vld);
        chk("data",  m_data_o,     ref_dat);
        chk("ovf",   credit_ovf_o, ref_ovf);
    endtask

    initial begin
        bit f;
        int owed;
        bit rx_rdy;
        bit drain;
        logic [DW-1:0] beat;

        // Reset with valid asserted: outputs must be quiet immediately.
        rst = 1'b1; s_valid_i = 1'b1; s_data_i = 8'h5A; m_credit_i = 1'b0;
        ref_reset();
        #1;
        chk("rst_ready", s_ready_o, 0);
        chk("rst_valid", m_valid_o, 0);
        chk("rst_cnt",   credit_cnt_o, 0);
        chk("rst_data",  m_data_o, 0);
        chk("rst_ovf",   credit_ovf_o, 0);
        @(negedge clk); rst = 1'b0;
        @(posedge clk); #1;
        for (int i = 0; i < 5; i++) cycle(1, 8'h5A, 0, f);

        // Credit init and single beat.
        cycle(0, 8'h00, 1, f);
        cycle(0, 8'h00, 1, f);
        chk("init_cnt", credit_cnt_o, 2);
        cycle(1, 8'hAA, 0, f);
        chk("aa_data", m_data_o, 8'hAA);

        // Exhaustion then one return releases the held beat.
        cycle(0, 8'h00, 1, f);
        cycle(1, 8'hBB, 0, f);
        cycle(1, 8'hCC, 0, f);
        cycle(1, 8'hDD, 0, f);
        chk("dd_held", f, 0);
        cycle(1, 8'hDD, 1, f);
        cycle(1, 8'hDD, 0, f);
        chk("dd_out", m_data_o, 8'hDD);
        chk("dd_cnt", credit_cnt_o, 0);

        // Simultaneous fire and credit at count 1.
        cycle(0, 8'h00, 1, f);
        cycle(1, 8'h11, 1, f);
        chk("sim_cnt", credit_cnt_o, 1);
        cycle(1, 8'h22, 0, f);
        chk("sim_acc", f, 1);

        // Overflow is sticky.
        cycle(0, 8'h00, 1, f);
        cycle(0, 8'h00, 1, f);
        cycle(0, 8'h00, 1, f);
        chk("ovf_set", credit_ovf_o, 1);
        chk("ovf_cnt", credit_cnt_o, 2);
        for (int i = 0; i < 3; i++) cycle(1, 8'(i), 1, f);

        // Hold: data unchanged when not firing.
        cycle(1, 8'h80, 0, f);
        cycle(0, 8'h50, 0, f);
        chk("hold_data", m_data_o, 8'h80);

        // Mid-operation reset drops the in-flight pulse and credits.
        cycle(1, 8'h77, 0, f);
        chk("pre_rst_vld", m_valid_o, 1);
        rst = 1'b1;
        #1;
        chk("mid_rst_vld", m_valid_o, 0);
        chk("mid_rst_cnt", credit_cnt_o, 0);
        chk("mid_rst_ovf", credit_ovf_o, 0);
        ref_reset();
        @(negedge clk); rst = 1'b0;
        @(posedge clk); #1;

        // End to end: receiver issues CN initial credits, then one per drained slot.
        owed = CN;
        beat = 8'h01;
        for (int i = 0; i < 400; i++) begin
            rx_rdy = (i >= 20) && ($urandom_range(0, 2) != 0);
            drain  = rx_rdy && (rx_q.size() > 0);
            if (drain) begin
                chk("e2e_order", rx_q.pop_front(), sent_q.pop_front());
                owed++;
            end
            cycle((i < 20) ? 1'b1 : 1'($urandom_range(0, 1)), beat, owed > 0, f);
            if (owed > 0) owed--;
            if (f) beat = beat + 8'h01;
            if (m_valid_o) rx_q.push_back(m_data_o);
            if (rx_q.size() > CN) chk("rx_room", rx_q.size(), CN);
        end
        for (int i = 0; i < 10; i++) begin
            if (rx_q.size() > 0) begin
                chk("e2e_tail", rx_q.pop_front(), sent_q.pop_front());
                owed++;
            end
            cycle(0, 8'h00, owed > 0, f);
            if (owed > 0) owed--;
        end
        chk("e2e_empty", sent_q.size(), 0);
        chk("e2e_ovf", credit_ovf_o, 0);
        chk("e2e_beats", (beat > 8'h04), 1);

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end
endmodule
